// File: rtl/servo_ramp_scheduler_if.sv
// Target-write channel between the SPI command decoder (master) and the
// servo ramp scheduler (slave).
interface servo_ramp_scheduler_if;
    logic       iWr_Valid;
    logic       oWr_Ready;
    logic [3:0] iWr_Ch;
    logic [7:0] iWr_Pos;

    modport master (
        output iWr_Valid,
        output iWr_Ch,
        output iWr_Pos,
        input  oWr_Ready
    );

    modport slave (
        input  iWr_Valid,
        input  iWr_Ch,
        input  iWr_Pos,
        output oWr_Ready
    );
endinterface

// File: rtl/servo_ramp_scheduler.sv
// Per-frame slew limiter for twelve servo control bytes.
// Optional feature macro: SERVO_LIMIT_EN clamps accepted targets to [MIN_POS, MAX_POS].
module servo_ramp_scheduler #(
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          FRAME_HZ  = 50,
    parameter int          NUM_CH    = 12,
    parameter int          STEP      = 2,
    parameter logic [7:0]  RESET_POS = 8'd128,
    parameter logic [7:0]  MIN_POS   = 8'd16,
    parameter logic [7:0]  MAX_POS   = 8'd240
) (
    input  logic                  clk,
    input  logic                  rst_n,
    servo_ramp_scheduler_if.slave wr_if,
    input  logic                  iHold,
    output logic [8*NUM_CH-1:0]   oPWM_Control_Sig,
    output logic                  oFrame_Tick,
    output logic                  oBusy,
    output logic                  oSettled
);

    localparam int FRAME_CYC = CLK_HZ / FRAME_HZ;
    localparam int CW        = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYC - 1);
    localparam logic [3:0]    CH_LAST  = 4'(NUM_CH - 1);
    localparam logic [8:0]    STEP_W   = 9'(STEP);
    localparam logic [7:0]    STEP_B   = 8'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tick_q;
    logic           ready_q;
    logic           busy_q;
    logic           settled_q;
    logic           eval_q;
    logic [7:0]     cur_q [NUM_CH];
    logic [7:0]     tgt_q [NUM_CH];
    logic           wr_fire_s;
    logic [7:0]     wr_pos_s;
    logic           all_eq_s;

    function automatic logic [7:0] clamp_pos(input logic [7:0] p);
        if (p < MIN_POS) begin
            return MIN_POS;
        end else if (p > MAX_POS) begin
            return MAX_POS;
        end else begin
            return p;
        end
    endfunction

    // Move cur at most STEP toward tgt; the 9-bit distance rules out wrap and overshoot.
    function automatic logic [7:0] step_pos(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] d;
        if (tgt >= cur) begin
            d = {1'b0, tgt} - {1'b0, cur};
        end else begin
            d = {1'b0, cur} - {1'b0, tgt};
        end
        if (d == 9'd0) begin
            return cur;
        end else if (d <= STEP_W) begin
            return tgt;
        end else if (tgt > cur) begin
            return cur + STEP_B;
        end else begin
            return cur - STEP_B;
        end
    endfunction

    assign wr_fire_s = wr_if.iWr_Valid && ready_q;

`ifdef SERVO_LIMIT_EN
    assign wr_pos_s = clamp_pos(wr_if.iWr_Pos);
`else
    assign wr_pos_s = wr_if.iWr_Pos;
`endif

    // Frame counter next value, wrapping at the terminal count.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Free-running frame counter and registered frame tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CNT_LAST);
        end
    end

    // Scan FSM next state and channel index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_q && !iHold) begin
                    state_d = ST_SCAN;
                    idx_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_q == CH_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    // FSM state register plus state-decoded handshake and busy flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= (state_d != ST_SCAN);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Target store; out-of-range channel writes match no entry and vanish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                tgt_q[k] <= RESET_POS;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_fire_s && (wr_if.iWr_Ch == 4'(k))) begin
                    tgt_q[k] <= wr_pos_s;
                end else begin
                    tgt_q[k] <= tgt_q[k];
                end
            end
        end
    end

    // Live positions: one channel stepped per SCAN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cur_q[k] <= RESET_POS;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ((state_q == ST_SCAN) && (idx_q == 4'(k))) begin
                    cur_q[k] <= step_pos(cur_q[k], tgt_q[k]);
                end else begin
                    cur_q[k] <= cur_q[k];
                end
            end
        end
    end

    // All-channels-settled comparison.
    always_comb begin
        all_eq_s = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_q[k] != tgt_q[k]) begin
                all_eq_s = 1'b0;
            end else begin
                all_eq_s = all_eq_s;
            end
        end
    end

    // Settled flag, refreshed at DONE and one cycle after each accepted write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eval_q    <= 1'b0;
            settled_q <= 1'b1;
        end else begin
            eval_q <= wr_fire_s;
            if ((state_q == ST_DONE) || eval_q) begin
                settled_q <= all_eq_s;
            end else begin
                settled_q <= settled_q;
            end
        end
    end

    // Flatten the position registers onto the PWM control bus.
    always_comb begin
        oPWM_Control_Sig = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            oPWM_Control_Sig[8*k +: 8] = cur_q[k];
        end
    end

    assign wr_if.oWr_Ready = ready_q;
    assign oFrame_Tick     = tick_q;
    assign oBusy           = busy_q;
    assign oSettled        = settled_q;

endmodule
